// File: rtl/decode_queue.sv
// Fetch-to-decode buffer: pre-decodes RV32I instructions at push time and holds them
// in a circular queue whose head entry is presented show-ahead to the issue logic.
`timescale 1ns/1ps
module decode_queue #(
  parameter int DEPTH_LOG = 3,
  parameter int AFULL_GAP = 1,
  parameter int ADDR_W    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rdy,
  input  logic                 i_rollback,
  input  logic                 i_if_inst_rdy,
  input  logic [31:0]          i_if_inst,
  input  logic [ADDR_W-1:0]    i_if_inst_pc,
  input  logic                 i_if_inst_pre_jump,
  output logic                 o_if_full,
  input  logic                 i_issue_ack,
  output logic                 o_out_valid,
  output logic [6:0]           o_out_opcode,
  output logic [2:0]           o_out_func3,
  output logic                 o_out_func1,
  output logic [4:0]           o_out_rd,
  output logic [4:0]           o_out_rs1,
  output logic [4:0]           o_out_rs2,
  output logic [31:0]          o_out_imm,
  output logic [ADDR_W-1:0]    o_out_pc,
  output logic                 o_out_pre_jump,
  output logic                 o_out_rs_en,
  output logic                 o_out_lsb_en,
  output logic                 o_out_is_store,
  output logic [DEPTH_LOG:0]   o_count
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int CNT_W = DEPTH_LOG + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic              func1;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] pc;
    logic              pre_jump;
    logic              rs_en;
    logic              lsb_en;
    logic              is_store;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [DEPTH_LOG-1:0]  r_head;
  logic [DEPTH_LOG-1:0]  r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_if_full;

  entry_t                w_ent;
  entry_t                w_out;
  logic                  w_known;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_next_count;
  logic [CNT_W-1:0]      w_next_free;

  always_comb begin
    w_ent          = '0;
    w_known        = 1'b1;
    w_ent.opcode   = i_if_inst[6:0];
    w_ent.func3    = i_if_inst[14:12];
    w_ent.func1    = i_if_inst[30];
    w_ent.pc       = i_if_inst_pc;
    w_ent.pre_jump = i_if_inst_pre_jump;
    case (i_if_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        w_ent.rd    = i_if_inst[11:7];
        w_ent.imm   = {i_if_inst[31:12], 12'b0};
        w_ent.rs_en = 1'b1;
      end
      OP_JAL: begin
        w_ent.rd    = i_if_inst[11:7];
        w_ent.imm   = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12],
                       i_if_inst[20], i_if_inst[30:21], 1'b0};
        w_ent.rs_en = 1'b1;
      end
      OP_JALR, OP_ARITHI: begin
        w_ent.rd    = i_if_inst[11:7];
        w_ent.rs1   = i_if_inst[19:15];
        w_ent.imm   = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        w_ent.rs_en = 1'b1;
      end
      OP_BRANCH: begin
        w_ent.rs1   = i_if_inst[19:15];
        w_ent.rs2   = i_if_inst[24:20];
        w_ent.imm   = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                       i_if_inst[30:25], i_if_inst[11:8], 1'b0};
        w_ent.rs_en = 1'b1;
      end
      OP_LOAD: begin
        w_ent.rd     = i_if_inst[11:7];
        w_ent.rs1    = i_if_inst[19:15];
        w_ent.imm    = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        w_ent.lsb_en = 1'b1;
      end
      OP_STORE: begin
        w_ent.rs1      = i_if_inst[19:15];
        w_ent.rs2      = i_if_inst[24:20];
        w_ent.imm      = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
        w_ent.lsb_en   = 1'b1;
        w_ent.is_store = 1'b1;
      end
      OP_ARITH: begin
        w_ent.rd    = i_if_inst[11:7];
        w_ent.rs1   = i_if_inst[19:15];
        w_ent.rs2   = i_if_inst[24:20];
        w_ent.rs_en = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_rdy && !i_rollback && (r_count != '0) && i_issue_ack;
  assign w_push = i_rdy && !i_rollback && i_if_inst_rdy && w_known &&
                  ((r_count != DEPTH_C) || w_pop);

  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + 1'b1;
      2'b01:   w_next_count = r_count - 1'b1;
      default: w_next_count = r_count;
    endcase
    w_next_free = DEPTH_C - w_next_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_if_full <= 1'b0;
    end else if (i_rdy) begin
      if (i_rollback) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
        r_if_full <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        r_count   <= w_next_count;
        r_if_full <= (int'(w_next_free) <= AFULL_GAP);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_tail] <= w_ent;
  end

  assign o_out_valid    = (r_count != '0);
  assign w_out          = o_out_valid ? r_mem[r_head] : '0;
  assign o_out_opcode   = w_out.opcode;
  assign o_out_func3    = w_out.func3;
  assign o_out_func1    = w_out.func1;
  assign o_out_rd       = w_out.rd;
  assign o_out_rs1      = w_out.rs1;
  assign o_out_rs2      = w_out.rs2;
  assign o_out_imm      = w_out.imm;
  assign o_out_pc       = w_out.pc;
  assign o_out_pre_jump = w_out.pre_jump;
  assign o_out_rs_en    = w_out.rs_en;
  assign o_out_lsb_en   = w_out.lsb_en;
  assign o_out_is_store = w_out.is_store;
  assign o_count        = r_count;
  assign o_if_full      = r_if_full;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: the driver queues hand-decoded expected entries,
// a negedge monitor compares the presented head, occupancy and backpressure.
`timescale 1ns/1ps
module tb_decode_queue;
  logic        i_clk = 1'b0;
  logic        i_rst, i_rdy, i_rollback, i_if_inst_rdy, i_if_inst_pre_jump, i_issue_ack;
  logic [31:0] i_if_inst, i_if_inst_pc;
  logic        o_if_full, o_out_valid, o_out_func1, o_out_pre_jump;
  logic        o_out_rs_en, o_out_lsb_en, o_out_is_store;
  logic [6:0]  o_out_opcode;
  logic [2:0]  o_out_func3;
  logic [4:0]  o_out_rd, o_out_rs1, o_out_rs2;
  logic [31:0] o_out_imm, o_out_pc;
  logic [3:0]  o_count;

  decode_queue #(.DEPTH_LOG(3), .AFULL_GAP(1), .ADDR_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdy(i_rdy), .i_rollback(i_rollback),
    .i_if_inst_rdy(i_if_inst_rdy), .i_if_inst(i_if_inst), .i_if_inst_pc(i_if_inst_pc),
    .i_if_inst_pre_jump(i_if_inst_pre_jump), .o_if_full(o_if_full),
    .i_issue_ack(i_issue_ack), .o_out_valid(o_out_valid), .o_out_opcode(o_out_opcode),
    .o_out_func3(o_out_func3), .o_out_func1(o_out_func1), .o_out_rd(o_out_rd),
    .o_out_rs1(o_out_rs1), .o_out_rs2(o_out_rs2), .o_out_imm(o_out_imm),
    .o_out_pc(o_out_pc), .o_out_pre_jump(o_out_pre_jump), .o_out_rs_en(o_out_rs_en),
    .o_out_lsb_en(o_out_lsb_en), .o_out_is_store(o_out_is_store), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f1;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pj, rs_en, lsb_en, st;
  } exp_t;

  localparam int NV = 12;
  logic [31:0] words [NV];
  exp_t        tbl   [NV];
  exp_t        exp_q [$];
  exp_t        act;
  logic        m_full;
  logic        mon_en = 1'b0;
  logic [31:0] pc_n = 32'h0;
  int          checks = 0;
  int          failures = 0;

  always_comb act = {o_out_opcode, o_out_func3, o_out_func1, o_out_rd, o_out_rs1, o_out_rs2,
                     o_out_imm, o_out_pc, o_out_pre_jump, o_out_rs_en, o_out_lsb_en, o_out_is_store};

  function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic rs, input logic lsb,
                              input logic st);
    exp_t e;
    e = '{op:op, f3:f3, f1:f1, rd:rd, rs1:rs1, rs2:rs2, imm:imm, pc:32'h0,
          pj:1'b0, rs_en:rs, lsb_en:lsb, st:st};
    return e;
  endfunction

  always @(negedge i_clk) begin
    exp_t drop;
    if (mon_en) begin
      checks++;
      if (o_out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL valid act=%0b exp=%0b", o_out_valid, exp_q.size() != 0);
      end
      checks++;
      if (o_count !== 4'(exp_q.size())) begin
        failures++;
        $display("FAIL count act=%0d exp=%0d", o_count, exp_q.size());
      end
      checks++;
      if (o_if_full !== m_full) begin
        failures++;
        $display("FAIL if_full act=%0b exp=%0b", o_if_full, m_full);
      end
      checks++;
      if (exp_q.size() != 0) begin
        if (act !== exp_q[0]) begin
          failures++;
          $display("FAIL head act=%h exp=%h", act, exp_q[0]);
        end
        if (i_rdy && i_issue_ack && !i_rollback && !i_rst) drop = exp_q.pop_front();
      end else if (act !== '0) begin
        failures++;
        $display("FAIL idle_zero act=%h exp=0", act);
      end
    end
  end

  // idx >= 0: table instruction, -2: unknown opcode, -1: no offer
  task automatic step(input int idx, input logic ack, input logic rb, input logic rdy_v);
    exp_t e;
    e = '0;
    i_rdy = rdy_v; i_issue_ack = ack; i_rollback = rb;
    i_if_inst_rdy = 1'b0; i_if_inst = 32'h0; i_if_inst_pc = pc_n; i_if_inst_pre_jump = 1'b0;
    if (idx >= 0) begin
      i_if_inst_rdy = 1'b1; i_if_inst = words[idx];
      i_if_inst_pre_jump = pc_n[2];
      e = tbl[idx]; e.pc = pc_n; e.pj = pc_n[2];
    end else if (idx == -2) begin
      i_if_inst_rdy = 1'b1; i_if_inst = 32'h0000007F;
    end
    @(posedge i_clk);
    if (i_rst) begin
      exp_q.delete(); m_full = 1'b0;
    end else if (rdy_v) begin
      if (rb) begin
        exp_q.delete(); m_full = 1'b0;
      end else begin
        if (idx >= 0 && exp_q.size() < 8) exp_q.push_back(e);
        m_full = (8 - exp_q.size()) <= 1;
      end
    end
    if (idx >= 0) pc_n = pc_n + 32'd4;
    #1;
  endtask

  initial begin
    words[0]  = 32'h00500093; tbl[0]  = mk(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000005, 1, 0, 0); // addi x1,x0,5
    words[1]  = 32'hFE212E23; tbl[1]  = mk(7'h23, 3'd2, 1'b1, 5'd0, 5'd2, 5'd2, 32'hFFFFFFFC, 0, 1, 1); // sw x2,-4(x2)
    words[2]  = 32'h123452B7; tbl[2]  = mk(7'h37, 3'd5, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 0, 0); // lui
    words[3]  = 32'h008000EF; tbl[3]  = mk(7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000008, 1, 0, 0); // jal x1,+8
    words[4]  = 32'h00208863; tbl[4]  = mk(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h00000010, 1, 0, 0); // beq +16
    words[5]  = 32'hFFF3A303; tbl[5]  = mk(7'h03, 3'd2, 1'b1, 5'd6, 5'd7, 5'd0, 32'hFFFFFFFF, 0, 1, 0); // lw x6,-1(x7)
    words[6]  = 32'h002081B3; tbl[6]  = mk(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h00000000, 1, 0, 0); // add
    words[7]  = 32'h402081B3; tbl[7]  = mk(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h00000000, 1, 0, 0); // sub
    words[8]  = 32'hFFFFF217; tbl[8]  = mk(7'h17, 3'd7, 1'b1, 5'd4, 5'd0, 5'd0, 32'hFFFFF000, 1, 0, 0); // auipc
    words[9]  = 32'h00008067; tbl[9]  = mk(7'h67, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'h00000000, 1, 0, 0); // jalr
    words[10] = 32'hFE009EE3; tbl[10] = mk(7'h63, 3'd1, 1'b1, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFC, 1, 0, 0); // bne -4
    words[11] = 32'hFE21AE23; tbl[11] = mk(7'h23, 3'd2, 1'b1, 5'd0, 5'd3, 5'd2, 32'hFFFFFFFC, 0, 1, 1); // sw x2,-4(x3)

    m_full = 1'b0;
    i_rst = 1'b1;
    step(-1, 0, 0, 1);
    mon_en = 1'b1;
    step(-1, 0, 0, 1);
    i_rst = 1'b0;
    step(-1, 0, 0, 1);

    step(0, 0, 0, 1);
    step(-1, 0, 0, 1);
    step(-1, 1, 0, 1);

    step(1, 0, 0, 1);
    step(11, 0, 0, 1);
    step(-1, 1, 0, 1);
    step(-1, 1, 0, 1);
    step(-1, 1, 0, 1);

    for (int k = 0; k < 8; k++) step(k, 0, 0, 1);
    step(8, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(-1, 1, 0, 1);
    for (int k = 8; k < 12; k++) step(k, 0, 0, 1);

    step(2, 1, 0, 1);
    step(10, 1, 0, 1);

    for (int k = 0; k < 3; k++) step(-1, 1, 0, 1);
    step(0, 1, 1, 1);
    step(-1, 0, 0, 1);

    step(3, 0, 0, 1);
    step(5, 0, 0, 1);
    step(7, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(4, 1, 1, 0);
    step(-2, 0, 0, 1);
    step(-2, 1, 0, 1);
    step(-1, 1, 0, 1);
    step(-1, 1, 0, 1);
    step(-1, 1, 0, 1);

    step(6, 0, 0, 1);
    step(9, 0, 0, 1);
    i_rst = 1'b1;
    step(1, 1, 0, 1);
    i_rst = 1'b0;
    step(-1, 0, 0, 1);
    step(-1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
